// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronized line, oversampled start/data/stop decoding, valid/ready output.
// Optional even-parity bit between data and stop, enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err,
    output logic                 busy
);
    localparam int TW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OS_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic                 sync1_q, sync2_q;
    logic                 rx_s;
    logic [1:0]           fill_q;
    logic                 armed_q, armed_d;
    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign rx_s = sync2_q;

    // fill_q tracks whether both synchronizer flops hold real line samples
    // since reset; until then the forced-high reset value must not arm a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            fill_q  <= 2'd0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            armed_q       <= 1'b0;
            tick_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q         <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            par_q         <= par_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q;
        tick_d        = tick_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        // A handshake consumes the word; a load on the same clk overrides below.
        rx_valid_d    = rx_valid_q & ~rx_ready;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d         = par_q;
        parity_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (rx_s && fill_q[1]) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (os_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (os_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (os_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        par_d   = rx_s;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (os_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ^{shift_q, par_q};
`endif
                        if (rx_s) begin
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_d  = shift_q;
                                rx_valid_d = 1'b1;
                            end else begin
                                overrun_err_d = 1'b1;
                            end
                        end else begin
                            // Line may still be in a break; wait for it to go high.
                            frame_err_d = 1'b1;
                            armed_d     = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed scenarios plus randomized frames against a frame-level model.
// Define UART_RX_PARITY_EN for both bench and design to cover the parity build.
`timescale 1ns/1ps
module tb_uart_receiver;
    localparam int DB     = 8;
    localparam int OS     = 16;
    localparam int DIV    = 4;
    localparam int BITCLK = OS * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS      = 2 + DB + PB;
    localparam int COMP_TICKS = OS / 2 + (DB + PB + 1) * OS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          os_tick = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_err, overrun_err, parity_err, busy;

    int vec = 0;
    int miscomp = 0;
    int n_ferr = 0, n_oerr = 0, n_perr = 0;
    int exp_ferr = 0, exp_oerr = 0, exp_perr = 0;
    logic [DB-1:0] got_q[$];
    logic [DB-1:0] exp_q[$];
    logic          m_valid = 1'b0;
    logic [DB-1:0] m_data = '0;

    uart_receiver #(.DATA_BITS(DB), .OS_RATE(OS)) dut (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .overrun_err(overrun_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        int div_cnt;
        div_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            div_cnt = (div_cnt + 1) % DIV;
            os_tick = (div_cnt == 0);
        end
    end

    // Observes pulses and consumed words away from the active edge.
    always @(negedge clk) begin
        if (frame_err)   n_ferr++;
        if (overrun_err) n_oerr++;
        if (parity_err)  n_perr++;
        if (rst && rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NBITS-1:0] build_line(input logic [DB-1:0] d, input logic stop, input logic par);
        logic [NBITS-1:0] l;
        l = '0;
        for (int i = 0; i < DB; i++) l[1+i] = d[i];
        if (PB == 1) l[1+DB] = par;
        l[NBITS-1] = stop;
        return l;
    endfunction

    // Frame-level reference: what one complete frame does to the observable state.
    task automatic model_frame(input logic [DB-1:0] d, input logic stop, input logic par,
                               input logic rdy_comp, input logic rdy_after);
        if (PB == 1 && ((^d) != par)) exp_perr++;
        if (!stop) begin
            exp_ferr++;
        end else if (m_valid && !rdy_comp) begin
            exp_oerr++;
        end else begin
            if (m_valid) exp_q.push_back(m_data);
            m_data  = d;
            m_valid = 1'b1;
            if (rdy_after) begin
                exp_q.push_back(d);
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic drive_ready(input logic r);
        @(posedge clk);
        #3;
        rx_ready = r;
        if (r && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
    endtask

    task automatic idle_line(input int clocks);
        for (int c = 0; c < clocks; c++) begin
            @(posedge clk);
            #3;
            rx = 1'b1;
        end
    endtask

    // ready_at_end raises rx_ready only for the clk whose edge samples the stop bit.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par, input bit ready_at_end);
        logic [NBITS-1:0] line;
        int n;
        line = build_line(d, stop, par);
        n = 0;
        for (int c = 0; c < NBITS * BITCLK; c++) begin
            @(posedge clk);
            #3;
            rx = line[c / BITCLK];
            if (ready_at_end) begin
                if (c >= 3 && os_tick) n++;
                rx_ready = (c >= 3 && os_tick && n == COMP_TICKS);
            end
        end
        @(posedge clk);
        #3;
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        vec++; if (rx_valid !== 1'b0) begin miscomp++; $display("FAIL reset_valid got %b want 0", rx_valid); end
        vec++; if (rx_data !== '0) begin miscomp++; $display("FAIL reset_data got %h want 00", rx_data); end
        vec++; if (busy !== 1'b0) begin miscomp++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
            miscomp++; $display("FAIL reset_errs got %b want 000", {frame_err, overrun_err, parity_err});
        end
        rst = 1'b1;
        idle_line(4);
        $display("reset: released");
    endtask

    task automatic test_frame_err;
        int f0;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0, ^8'h3C, 1'b0, 1'b0);
        idle_line(BITCLK);
        @(negedge clk);
        vec++; if (n_ferr - f0 !== 1) begin miscomp++; $display("FAIL ferr_pulses got %0d want 1", n_ferr - f0); end
        vec++; if (rx_valid !== 1'b0) begin miscomp++; $display("FAIL ferr_valid got %b want 0", rx_valid); end
        vec++; if (rx_data !== 8'h00) begin miscomp++; $display("FAIL ferr_data got %h want 00", rx_data); end
        $display("frame_err: data=3C stop=0 -> rx_valid=%b rx_data=%h", rx_valid, rx_data);
    endtask

    task automatic test_false_start;
        for (int c = 0; c < 5 * DIV; c++) begin
            @(posedge clk);
            #3;
            rx = 1'b0;
        end
        @(negedge clk);
        vec++; if (busy !== 1'b1) begin miscomp++; $display("FAIL fs_busy_high got %b want 1", busy); end
        idle_line(3 * BITCLK);
        @(negedge clk);
        vec++; if (busy !== 1'b0) begin miscomp++; $display("FAIL fs_busy_low got %b want 0", busy); end
        vec++; if (rx_valid !== 1'b0) begin miscomp++; $display("FAIL fs_valid got %b want 0", rx_valid); end
        vec++; if (n_ferr !== exp_ferr) begin miscomp++; $display("FAIL fs_ferr got %0d want %0d", n_ferr, exp_ferr); end
        $display("false_start: busy=%b rx_valid=%b", busy, rx_valid);
    endtask

    task automatic test_basic;
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
        model_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, 1'b0);
        idle_line(2 * BITCLK);
        @(negedge clk);
        vec++; if (rx_data !== 8'hA5) begin miscomp++; $display("FAIL basic_data got %h want a5", rx_data); end
        vec++; if (rx_valid !== 1'b1) begin miscomp++; $display("FAIL basic_valid got %b want 1", rx_valid); end
        vec++; if ({n_ferr, n_oerr, n_perr} !== {exp_ferr, exp_oerr, exp_perr}) begin
            miscomp++; $display("FAIL basic_errs got %0d/%0d/%0d want %0d/%0d/%0d", n_ferr, n_oerr, n_perr, exp_ferr, exp_oerr, exp_perr);
        end
        idle_line(4 * BITCLK);
        @(negedge clk);
        vec++; if (rx_valid !== 1'b1) begin miscomp++; $display("FAIL basic_hold got %b want 1", rx_valid); end
        $display("basic: data=A5 -> rx_data=%h rx_valid=%b", rx_data, rx_valid);
    endtask

    task automatic test_overrun;
        int o0;
        logic [DB-1:0] g;
        drive_ready(1'b1);
        drive_ready(1'b0);
        o0 = n_oerr;
        send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
        model_frame(8'h11, 1'b1, ^8'h11, 1'b0, 1'b0);
        idle_line(BITCLK);
        send_frame(8'h22, 1'b1, ^8'h22, 1'b0);
        model_frame(8'h22, 1'b1, ^8'h22, 1'b0, 1'b0);
        idle_line(BITCLK);
        @(negedge clk);
        vec++; if (rx_data !== 8'h11) begin miscomp++; $display("FAIL ovr_data got %h want 11", rx_data); end
        vec++; if (n_oerr - o0 !== 1) begin miscomp++; $display("FAIL ovr_pulses got %0d want 1", n_oerr - o0); end
        vec++; if (rx_valid !== 1'b1) begin miscomp++; $display("FAIL ovr_valid got %b want 1", rx_valid); end
        $display("overrun: 11 then 22 rdy=0 -> rx_data=%h", rx_data);
        send_frame(8'h22, 1'b1, ^8'h22, 1'b1);
        model_frame(8'h22, 1'b1, ^8'h22, 1'b1, 1'b0);
        idle_line(BITCLK);
        @(negedge clk);
        vec++; if (rx_data !== 8'h22) begin miscomp++; $display("FAIL ovr2_data got %h want 22", rx_data); end
        vec++; if (rx_valid !== 1'b1) begin miscomp++; $display("FAIL ovr2_valid got %b want 1", rx_valid); end
        vec++; if (n_oerr - o0 !== 1) begin miscomp++; $display("FAIL ovr2_pulses got %0d want 1", n_oerr - o0); end
        vec++; if (got_q.size() !== exp_q.size()) begin
            miscomp++; $display("FAIL ovr_consumed_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            vec++; if (g !== exp_q[0]) begin miscomp++; $display("FAIL ovr_consumed got %h want %h", g, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        $display("overrun: 22 with ready at completion -> rx_data=%h rx_valid=%b", rx_data, rx_valid);
    endtask

    task automatic test_mid_reset;
        logic [NBITS-1:0] line;
        line = build_line(8'hFF, 1'b1, ^8'hFF);
        for (int c = 0; c < NBITS * BITCLK; c++) begin
            @(posedge clk);
            #3;
            rx = line[c / BITCLK];
            if (c == 4 * BITCLK + BITCLK / 2) begin
                #1;
                rst = 1'b0;
                #0.5;
                vec++; if (rx_valid !== 1'b0) begin miscomp++; $display("FAIL mrst_valid got %b want 0", rx_valid); end
                vec++; if (rx_data !== '0) begin miscomp++; $display("FAIL mrst_data got %h want 00", rx_data); end
                vec++; if (busy !== 1'b0) begin miscomp++; $display("FAIL mrst_busy got %b want 0", busy); end
                vec++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
                    miscomp++; $display("FAIL mrst_errs got %b want 000", {frame_err, overrun_err, parity_err});
                end
            end
            if (c == 4 * BITCLK + BITCLK / 2 + 4) rst = 1'b1;
        end
        m_valid = 1'b0;
        m_data  = '0;
        idle_line(BITCLK);
        @(negedge clk);
        vec++; if (rx_valid !== 1'b0) begin miscomp++; $display("FAIL mrst_tail_valid got %b want 0", rx_valid); end
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
        model_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, 1'b0);
        idle_line(BITCLK);
        @(negedge clk);
        vec++; if (rx_data !== 8'h5A) begin miscomp++; $display("FAIL mrst_next_data got %h want 5a", rx_data); end
        vec++; if (rx_valid !== 1'b1) begin miscomp++; $display("FAIL mrst_next_valid got %b want 1", rx_valid); end
        $display("mid_reset: after reset, frame 5A -> rx_data=%h rx_valid=%b", rx_data, rx_valid);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int p0;
        for (int k = 0; k < 2; k++) begin
            drive_ready(1'b1);
            drive_ready(1'b0);
            p0 = n_perr;
            send_frame(8'h07, 1'b1, k[0], 1'b0);
            model_frame(8'h07, 1'b1, k[0], 1'b0, 1'b0);
            idle_line(BITCLK);
            @(negedge clk);
            vec++; if (n_perr - p0 !== (k == 0 ? 1 : 0)) begin
                miscomp++; $display("FAIL parity_pulses par=%0d got %0d want %0d", k, n_perr - p0, (k == 0 ? 1 : 0));
            end
            vec++; if (rx_data !== 8'h07) begin miscomp++; $display("FAIL parity_data got %h want 07", rx_data); end
            $display("parity: data=07 par=%0d -> parity pulses %0d", k, n_perr - p0);
        end
    endtask
`endif

    task automatic test_random;
        logic [DB-1:0] d, g;
        logic stop, par, r;
        for (int f = 0; f < 24; f++) begin
            r = 1'($urandom_range(0, 1));
            drive_ready(r);
            d    = DB'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, stop, par, 1'b0);
            model_frame(d, stop, par, r, r);
            idle_line(BITCLK + int'($urandom_range(0, BITCLK)));
            @(negedge clk);
            vec++; if (rx_valid !== m_valid) begin miscomp++; $display("FAIL rand%0d_valid got %b want %b", f, rx_valid, m_valid); end
            vec++; if (rx_data !== m_data) begin miscomp++; $display("FAIL rand%0d_data got %h want %h", f, rx_data, m_data); end
            vec++; if (n_ferr !== exp_ferr) begin miscomp++; $display("FAIL rand%0d_ferr got %0d want %0d", f, n_ferr, exp_ferr); end
            vec++; if (n_oerr !== exp_oerr) begin miscomp++; $display("FAIL rand%0d_oerr got %0d want %0d", f, n_oerr, exp_oerr); end
            vec++; if (n_perr !== exp_perr) begin miscomp++; $display("FAIL rand%0d_perr got %0d want %0d", f, n_perr, exp_perr); end
            vec++; if (busy !== 1'b0) begin miscomp++; $display("FAIL rand%0d_busy got %b want 0", f, busy); end
            vec++; if (got_q.size() !== exp_q.size()) begin
                miscomp++; $display("FAIL rand%0d_consumed_count got %0d want %0d", f, got_q.size(), exp_q.size());
            end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front();
                vec++; if (g !== exp_q[0]) begin miscomp++; $display("FAIL rand%0d_consumed got %h want %h", f, g, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            $display("frame %0d: data=%h stop=%b par=%b rdy=%b -> rx_data=%h rx_valid=%b", f, d, stop, par, r, rx_data, rx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_frame_err();
        test_false_start();
        test_basic();
        test_overrun();
        test_mid_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame (legal 5..8).
REQ-002 SHALL have parameter OS_RATE, default 16, meaning the number of os_tick pulses per bit period.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port os_tick, input, 1 bit: one-clk-wide oversample enable from the baud generator, OS_RATE per bit.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port rx_ready, input, 1 bit: consumer accepts rx_data when high with rx_valid high.
REQ-008 SHALL have port rx_data, output, DATA_BITS bits: last received word, LSB first on the line.
REQ-009 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed word.
REQ-010 SHALL have port frame_err, output, 1 bit: one-clk pulse, stop bit sampled low.
REQ-011 SHALL have port overrun_err, output, 1 bit: one-clk pulse, word completed while rx_valid still high.
REQ-012 SHALL have port parity_err, output, 1 bit: one-clk pulse, parity mismatch; tied 0 when parity is compiled out.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (2-clk latency).
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY, STOP; a tick counter (0..OS_RATE-1) and a bit counter advance only on os_tick.
REQ-016 IDLE: on a synchronized rx value of 0, SHALL go to START with the tick counter cleared.
REQ-017 START: at tick OS_RATE/2-1, rx=0 -> DATA with counters cleared; rx=1 -> IDLE as a false start, with no output change.
REQ-018 DATA: every OS_RATE ticks, SHALL sample rx into the shift register MSB and shift right; after DATA_BITS samples, go to PARITY (if enabled) else STOP.
REQ-019 PARITY: after OS_RATE ticks, SHALL sample the parity bit, then go to STOP.
REQ-020 STOP: after OS_RATE ticks, SHALL sample the stop bit and return to IDLE on the same clk; completion actions occur on that clk.
REQ-021 Completion with stop=1 and rx_valid=0 (or rx_valid=1 and rx_ready=1 on that clk): SHALL load rx_data and set rx_valid.
REQ-022 Completion with stop=1, rx_valid=1 and rx_ready=0: SHALL pulse overrun_err and drop the new word; rx_data and rx_valid are unchanged.
REQ-023 Completion with stop=0: SHALL pulse frame_err, drop the word and leave rx_valid unchanged; IDLE then waits for rx=1 before re-arming.
REQ-024 SHALL clear rx_valid on the clk after rx_valid & rx_ready, unless a new word loads on the same clk (REQ-021).
REQ-025 While rx_valid is high, rx_data SHALL be stable.
REQ-026 os_tick SHALL be ignored in IDLE; clk cycles without os_tick SHALL not advance any counter.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, counters 0, rx_data 0, rx_valid 0, all error pulses 0 and busy 0.
REQ-028 rst=0 SHALL force the synchronizer flops to 1 (line idle).
REQ-029 A reset mid-frame SHALL discard the partial word; the remainder of that frame is not decoded as a new start until rx is seen high.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL exist, check even parity over the data bits, and pulse parity_err at completion; the word is still delivered per REQ-021/022.
REQ-031 Without UART_RX_PARITY_EN, PARITY SHALL be unreachable, the frame SHALL be start+DATA_BITS+stop, and parity_err SHALL be constant 0.

Verification
REQ-032 os_tick every 4 clk, frame 0xA5 (8N1), rx_ready=0 -> rx_data=0xA5, rx_valid=1 held, no error pulses.
REQ-033 rx low for 5 os_ticks then high -> no START-to-DATA transition, busy returns 0, rx_valid stays 0.
REQ-034 Frame 0x3C with stop bit 0 -> single frame_err pulse, rx_valid 0, rx_data 0.
REQ-035 0x11 then 0x22, rx_ready=0 throughout -> rx_data=0x11, one overrun_err pulse; repeat with rx_ready=1 at the second completion -> rx_data=0x22, rx_valid=1, no overrun.
REQ-036 rst pulsed low during data bit 3 of 0xFF -> all outputs 0 immediately; the next clean 0x5A frame is received correctly.
REQ-037 With UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err pulse and rx_data=0x07; with parity bit 1 -> no parity_err.
